spi_pixel_loader: RTL and testbench
===================================

// Module: spi_pixel_loader
// PURPOSE
//  SPI-slave front end that feeds the pixel byte buffer (pixelData) on its load side.
//  - Deserialises MSB-first bytes from an external SPI master.
//  - Drives the buffer's spi_in / shift_SPI / write_en load interface, one byte per pulse.
//  - Counts a full 72-byte image and raises frame_ready to the network controller.
//  - Holds off further loads until the controller acknowledges the frame.
// PARAMETERS
//  NUM_BYTES    72  bytes per image frame (pixel buffer depth)
//  BYTE_W        8  bits per pixel byte
//  SYNC_STAGES   2  flip-flop stages on each asynchronous SPI input
// PORTS
//  clk           in   1      system clock; all logic on rising edge
//  rst           in   1      synchronous reset, active-high
//  sclk          in   1      SPI clock from master, asynchronous; sampled on its rising edge
//  ss_n          in   1      SPI slave select, active-low, asynchronous
//  mosi          in   1      SPI data, MSB first, asynchronous
//  frame_ack     in   1      one-cycle pulse: frame consumed, re-arm the loader
//  spi_in        out  [0:7]  assembled byte; bit 0 = first (MSB) bit received
//  shift_SPI     out  1      one-cycle pulse: advance pixel buffer
//  write_en      out  1      one-cycle pulse, coincident with shift_SPI
//  frame_ready   out  1      level: NUM_BYTES bytes loaded since last ack
//  byte_count    out  7      bytes loaded in current frame, 0..NUM_BYTES
//  overrun_err   out  1      sticky: a byte arrived while frame_ready=1
// BEHAVIOUR
//  Reset values
//  - All outputs are 0 on reset; state returns to IDLE.
//  - Synchroniser flops reset: sclk low, ss_n high, mosi low.
//  - Reset asserted mid-byte or mid-frame discards all partial data.
//  Input sampling
//  - sclk, ss_n and mosi each pass through SYNC_STAGES flops.
//  - A sclk rising edge is detected one cycle later, on the synchronised value.
//  - Master timing requirement: sclk high and low times >= 3 clk periods.
//  State machine
//  - IDLE:
//    - ss_n low -> RECV; bit_cnt = 0.
//  - RECV, on each detected sclk rise:
//    - sreg <= {sreg[1:7], mosi_sync}; bit_cnt++.
//    - 8th bit -> PUSH.
//    - ss_n high before the 8th bit: drop partial bits, bit_cnt = 0, -> IDLE.
//    - byte_count is unchanged on such an abort.
//  - PUSH (exactly 1 cycle):
//    - spi_in <= sreg; shift_SPI = write_en = 1; byte_count++.
//    - Registered outputs: the pulse appears the cycle after the 8th bit is captured.
//    - If the new byte_count == NUM_BYTES: frame_ready <= 1 -> FULL.
//    - Otherwise -> RECV if ss_n low, else IDLE.
//  - FULL:
//    - SPI bytes are still shifted in but never pushed.
//    - Each completed byte sets overrun_err.
//    - frame_ack -> frame_ready = 0, byte_count = 0, overrun_err = 0, -> IDLE.
//  Output hold and ack rules
//  - spi_in holds the last pushed byte between pulses; never changes without a pulse.
//  - shift_SPI and write_en are never high for two consecutive cycles.
//  - Minimum spacing between pulses is >= 8 sclk periods.
//  - frame_ack outside FULL is ignored.
//  Boundary conditions
//  - frame_ack in the same cycle a byte completes in FULL:
//    - The byte is dropped and overrun_err is set (set wins).
//    - frame_ready and byte_count clear.
//  - ss_n rising in the same cycle as the 8th sclk edge: the byte completes and is pushed.
//  - byte_count saturates at NUM_BYTES; it never wraps.
// STRUCTURE
//  - Package pixel_pkg:
//    - NUM_PIXEL_BYTES = 72 and PIXEL_W = 8.
//    - typedef logic [0:7] pixel_t.
//    - typedef enum {IDLE, RECV, PUSH, FULL} loader_state_t.
//  - Sub-module spi_sync_edge:
//    - SYNC_STAGES synchroniser plus registered rise/fall detect.
//    - Instantiated once per SPI input.
//  - Top level holds the FSM, bit counter, byte counter and output registers.
// TESTING
//  - Two bytes 0xFF then 0xAA:
//    - Two single-cycle shift_SPI/write_en pulses.
//    - spi_in = 8'hFF then 8'hAA; byte_count = 2.
//  - Bytes 0..71 back-to-back:
//    - 72 pulses; frame_ready rises the cycle after the 72nd pulse.
//    - byte_count = 72; spi_in = 8'd71.
//  - 73rd byte 0x55 while FULL:
//    - No pulse; spi_in stays 8'd71; overrun_err = 1.
//    - frame_ack then clears frame_ready, byte_count and overrun_err.
//  - Partial-byte abort:
//    - 5 bits, then ss_n high, then byte 0x3C.
//    - Exactly one pulse with spi_in = 8'h3C; byte_count = 1.
//  - rst asserted after 4 bits of byte 0x81:
//    - All outputs 0 next cycle.
//    - A subsequent full byte 0x81 gives one pulse, spi_in = 8'h81.
//  - frame_ack coincident with byte completion in FULL:
//    - frame_ready = 0, byte_count = 0, overrun_err = 1, no pulse.

Source files
------------

// File: rtl/pixel_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared types and constants for the SPI pixel loader: frame
//               depth, pixel byte type, counter widths, loader FSM states
//               and a saturating byte-counter increment.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    localparam int NUM_PIXEL_BYTES = 72;
    localparam int PIXEL_W         = 8;
    localparam int BYTE_CNT_W      = 7;
    localparam int BIT_CNT_W       = $clog2(PIXEL_W);

    // Bit 0 holds the first (most significant) bit received on the wire.
    typedef logic [0:PIXEL_W-1]    pixel_t;
    typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PUSH = 2'd2,
        FULL = 2'd3
    } loader_state_t;

    // Increment that sticks at the limit instead of wrapping.
    function automatic byte_cnt_t sat_inc(input byte_cnt_t value, input byte_cnt_t limit);
        if (value >= limit) begin
            return limit;
        end
        return value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pixel_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_pixel_loader_if
// Description : Bundle of the SPI pins, the frame acknowledge and the pixel
//               buffer load interface of the SPI pixel loader.
//               master : drives sclk/ss_n/mosi/frame_ack, observes loader outputs
//               slave  : the loader itself
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_pixel_loader_if;
    import pixel_pkg::*;

    logic      sclk;
    logic      ss_n;
    logic      mosi;
    logic      frame_ack;
    pixel_t    spi_in;
    logic      shift_SPI;
    logic      write_en;
    logic      frame_ready;
    byte_cnt_t byte_count;
    logic      overrun_err;

    modport master (
        output sclk, ss_n, mosi, frame_ack,
        input  spi_in, shift_SPI, write_en, frame_ready, byte_count, overrun_err
    );

    modport slave (
        input  sclk, ss_n, mosi, frame_ack,
        output spi_in, shift_SPI, write_en, frame_ready, byte_count, overrun_err
    );

endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchroniser for one asynchronous input followed by
//               registered rising/falling edge detection.
//   clk, rst  : system clock, synchronous active-high reset
//   i_async   : asynchronous input
//   o_level   : synchronised level
//   o_rise    : one-cycle pulse, one cycle after o_level goes high
//   o_fall    : one-cycle pulse, one cycle after o_level goes low
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= RESET_VAL;
                end else begin
                    r_sync <= i_async;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= {SYNC_STAGES{RESET_VAL}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
                end
            end
        end
    endgenerate

    assign o_level = r_sync[SYNC_STAGES-1];

    // Previous level resets to the idle value so reset release never looks
    // like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= o_level;
            r_rise <= o_level & ~r_prev;
            r_fall <= ~o_level & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_pixel_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_pixel_loader
// Description : SPI-slave front end feeding the pixel byte buffer. Assembles
//               MSB-first bytes, pushes each into the buffer with a one-cycle
//               shift_SPI/write_en pulse, counts a full frame and holds off
//               further loads until the frame is acknowledged.
//   clk, rst          : system clock, synchronous active-high reset
//   bus.sclk/ss_n/mosi: asynchronous SPI pins from the master
//   bus.frame_ack     : pulse, frame consumed, re-arm the loader
//   bus.spi_in        : last pushed byte (bit 0 = first bit received)
//   bus.shift_SPI     : one-cycle pulse per pushed byte
//   bus.write_en      : identical to shift_SPI
//   bus.frame_ready   : level, NUM_BYTES bytes loaded since last ack
//   bus.byte_count    : bytes loaded in current frame
//   bus.overrun_err   : sticky, a byte completed while the frame was full
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pixel_loader
    import pixel_pkg::*;
#(
    parameter int NUM_BYTES   = NUM_PIXEL_BYTES,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    spi_pixel_loader_if.slave  bus
);

    localparam logic [BIT_CNT_W-1:0] c_last_bit   = BIT_CNT_W'(PIXEL_W - 1);
    localparam byte_cnt_t            c_full_count = BYTE_CNT_W'(NUM_BYTES);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_ss_n, w_ss_n_rise, w_ss_n_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(bus.sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
        .clk(clk), .rst(rst), .i_async(bus.ss_n),
        .o_level(w_ss_n), .o_rise(w_ss_n_rise), .o_fall(w_ss_n_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_async(bus.mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    loader_state_t        r_state;
    loader_state_t        w_next_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    pixel_t               r_sreg;
    pixel_t               r_spi_in;
    logic                 r_pulse;
    byte_cnt_t            r_byte_count;
    logic                 r_frame_ready;
    logic                 r_overrun;

    // Only the sclk rise is consumed; the oldest shift bit is always
    // shifted out and never read.
    logic w_unused_edges;
    assign w_unused_edges = |{w_sclk_level, w_sclk_fall, w_ss_n_rise, w_ss_n_fall,
                              w_mosi_rise, w_mosi_fall, r_sreg[0]};

    logic   w_last_bit;
    pixel_t w_byte_next;

    assign w_last_bit  = w_sclk_rise && (r_bit_cnt == c_last_bit);
    assign w_byte_next = {r_sreg[1:PIXEL_W-1], w_mosi};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath controls
    // ------------------------------------------------------------------
    logic w_shift;
    logic w_clear_bits;
    logic w_load;
    logic w_frame_set;
    logic w_ack;
    logic w_overrun_set;

    always_comb begin
        w_next_state  = r_state;
        w_shift       = 1'b0;
        w_clear_bits  = 1'b0;
        w_load        = 1'b0;
        w_frame_set   = 1'b0;
        w_ack         = 1'b0;
        w_overrun_set = 1'b0;

        case (r_state)
            IDLE: begin
                w_clear_bits = 1'b1;
                if (!w_ss_n) begin
                    w_next_state = RECV;
                end
            end

            RECV: begin
                w_shift = w_sclk_rise;
                // A completing 8th bit wins over a simultaneous deselect.
                if (w_last_bit) begin
                    w_load       = 1'b1;
                    w_next_state = PUSH;
                end else if (w_ss_n) begin
                    w_clear_bits = 1'b1;
                    w_next_state = IDLE;
                end
            end

            PUSH: begin
                // byte_count already holds the value including this byte.
                if (r_byte_count == c_full_count) begin
                    w_frame_set  = 1'b1;
                    w_next_state = FULL;
                end else if (w_ss_n) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RECV;
                end
            end

            FULL: begin
                // Keep bit alignment so overruns are reported per byte.
                w_shift = w_sclk_rise;
                if (w_last_bit) begin
                    w_overrun_set = 1'b1;
                end else if (w_ss_n) begin
                    w_clear_bits = 1'b1;
                end
                if (bus.frame_ack) begin
                    w_ack        = 1'b1;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_sreg        <= '0;
            r_spi_in      <= '0;
            r_pulse       <= 1'b0;
            r_byte_count  <= '0;
            r_frame_ready <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_shift) begin
                r_sreg    <= w_byte_next;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_clear_bits) begin
                r_bit_cnt <= '0;
            end

            // Loading at the capture edge puts the pulse, the byte and the
            // updated count on the outputs in the same (PUSH) cycle.
            r_pulse <= w_load;
            if (w_load) begin
                r_spi_in     <= w_byte_next;
                r_byte_count <= sat_inc(r_byte_count, c_full_count);
            end

            if (w_frame_set) begin
                r_frame_ready <= 1'b1;
            end
            if (w_ack) begin
                r_frame_ready <= 1'b0;
                r_byte_count  <= '0;
            end

            // A byte completing in the ack cycle still flags the overrun.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_ack) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.spi_in      = r_spi_in;
    assign bus.shift_SPI   = r_pulse;
    assign bus.write_en    = r_pulse;
    assign bus.frame_ready = r_frame_ready;
    assign bus.byte_count  = r_byte_count;
    assign bus.overrun_err = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_pixel_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_pixel_loader
// Description : Directed self-checking bench for spi_pixel_loader. Drives an
//               SPI master (sclk high/low 4 clk periods each) and checks the
//               load pulses, assembled bytes, frame handling and overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_pixel_loader;
    import pixel_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_pixel_loader_if u_if ();

    spi_pixel_loader #(
        .NUM_BYTES   (72),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Output monitor (samples on the falling clock edge)
    // ------------------------------------------------------------------
    int         cyc            = 0;
    int         pulse_cnt      = 0;
    int         last_pulse_cyc = -1;
    int         fr_rise_cyc    = -1;
    int         consec_err     = 0;
    int         we_err         = 0;
    int         hold_err       = 0;
    logic [7:0] pulse_data [0:255];
    logic       prev_pulse     = 1'b0;
    logic       prev_fr        = 1'b0;
    logic       prev_rst       = 1'b1;
    logic [7:0] prev_spi       = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (u_if.shift_SPI === 1'b1) begin
            if (pulse_cnt < 256) pulse_data[pulse_cnt] = u_if.spi_in;
            pulse_cnt++;
            last_pulse_cyc = cyc;
            if (prev_pulse) consec_err++;
        end
        if (u_if.write_en !== u_if.shift_SPI) we_err++;
        if (u_if.frame_ready === 1'b1 && !prev_fr) fr_rise_cyc = cyc;
        if (!rst && !prev_rst && u_if.shift_SPI !== 1'b1 && u_if.spi_in !== prev_spi) hold_err++;
        prev_pulse = (u_if.shift_SPI === 1'b1);
        prev_fr    = (u_if.frame_ready === 1'b1);
        prev_rst   = rst;
        prev_spi   = u_if.spi_in;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all times stay aligned to posedge + 1 ns)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        u_if.sclk      = 1'b0;
        u_if.ss_n      = 1'b1;
        u_if.mosi      = 1'b0;
        u_if.frame_ack = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(3);
    endtask

    task automatic send_bit(input logic b);
        u_if.mosi = b;
        #40 u_if.sclk = 1'b1;
        #40 u_if.sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic select();
        u_if.ss_n = 1'b0;
        #40;
    endtask

    task automatic deselect();
        u_if.ss_n = 1'b1;
        #40;
    endtask

    task automatic fill_frame();
        for (int i = 0; i < 72; i++) send_byte(8'(i));
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++; if (u_if.spi_in !== 8'h00) begin failures++; $display("FAIL reset_spi_in: got %0h expected 0", u_if.spi_in); end
        checks++; if (u_if.shift_SPI !== 1'b0) begin failures++; $display("FAIL reset_shift: got %0b expected 0", u_if.shift_SPI); end
        checks++; if (u_if.write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en: got %0b expected 0", u_if.write_en); end
        checks++; if (u_if.frame_ready !== 1'b0) begin failures++; $display("FAIL reset_frame_ready: got %0b expected 0", u_if.frame_ready); end
        checks++; if (u_if.byte_count !== 7'd0) begin failures++; $display("FAIL reset_byte_count: got %0d expected 0", u_if.byte_count); end
        checks++; if (u_if.overrun_err !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", u_if.overrun_err); end
    endtask

    task automatic test_two_bytes();
        int base;
        do_reset();
        base = pulse_cnt;
        select();
        send_byte(8'hFF);
        send_byte(8'hAA);
        idle(4);
        deselect();
        checks++; if (pulse_cnt - base !== 2) begin failures++; $display("FAIL two_pulses: got %0d expected 2", pulse_cnt - base); end
        checks++; if (pulse_data[base] !== 8'hFF) begin failures++; $display("FAIL two_first_byte: got %0h expected ff", pulse_data[base]); end
        checks++; if (pulse_data[base+1] !== 8'hAA) begin failures++; $display("FAIL two_second_byte: got %0h expected aa", pulse_data[base+1]); end
        checks++; if (u_if.spi_in !== 8'hAA) begin failures++; $display("FAIL two_spi_in_hold: got %0h expected aa", u_if.spi_in); end
        checks++; if (u_if.byte_count !== 7'd2) begin failures++; $display("FAIL two_byte_count: got %0d expected 2", u_if.byte_count); end
    endtask

    task automatic test_full_frame();
        int base;
        int bad;
        do_reset();
        base = pulse_cnt;
        select();
        fill_frame();
        idle(4);
        bad = 0;
        for (int i = 0; i < 72; i++) if (pulse_data[base+i] !== 8'(i)) bad++;
        checks++; if (pulse_cnt - base !== 72) begin failures++; $display("FAIL frame_pulses: got %0d expected 72", pulse_cnt - base); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL frame_data: got %0d wrong bytes expected 0", bad); end
        checks++; if (u_if.byte_count !== 7'd72) begin failures++; $display("FAIL frame_byte_count: got %0d expected 72", u_if.byte_count); end
        checks++; if (u_if.spi_in !== 8'd71) begin failures++; $display("FAIL frame_spi_in: got %0d expected 71", u_if.spi_in); end
        checks++; if (u_if.frame_ready !== 1'b1) begin failures++; $display("FAIL frame_ready_set: got %0b expected 1", u_if.frame_ready); end
        checks++; if (fr_rise_cyc !== last_pulse_cyc + 1) begin failures++; $display("FAIL frame_ready_timing: got cycle %0d expected %0d", fr_rise_cyc, last_pulse_cyc + 1); end
    endtask

    // Continues from the full frame left by test_full_frame.
    task automatic test_overrun_and_ack();
        int base;
        base = pulse_cnt;
        send_byte(8'h55);
        idle(4);
        checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL overrun_no_pulse: got %0d expected 0", pulse_cnt - base); end
        checks++; if (u_if.spi_in !== 8'd71) begin failures++; $display("FAIL overrun_spi_in: got %0d expected 71", u_if.spi_in); end
        checks++; if (u_if.overrun_err !== 1'b1) begin failures++; $display("FAIL overrun_set: got %0b expected 1", u_if.overrun_err); end
        checks++; if (u_if.byte_count !== 7'd72) begin failures++; $display("FAIL overrun_count_sat: got %0d expected 72", u_if.byte_count); end
        u_if.frame_ack = 1'b1;
        idle(1);
        u_if.frame_ack = 1'b0;
        idle(2);
        checks++; if (u_if.frame_ready !== 1'b0) begin failures++; $display("FAIL ack_frame_ready: got %0b expected 0", u_if.frame_ready); end
        checks++; if (u_if.byte_count !== 7'd0) begin failures++; $display("FAIL ack_byte_count: got %0d expected 0", u_if.byte_count); end
        checks++; if (u_if.overrun_err !== 1'b0) begin failures++; $display("FAIL ack_overrun: got %0b expected 0", u_if.overrun_err); end
        deselect();
    endtask

    task automatic test_abort();
        int base;
        do_reset();
        base = pulse_cnt;
        select();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        deselect();
        select();
        send_byte(8'h3C);
        idle(4);
        deselect();
        checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL abort_pulses: got %0d expected 1", pulse_cnt - base); end
        checks++; if (u_if.spi_in !== 8'h3C) begin failures++; $display("FAIL abort_spi_in: got %0h expected 3c", u_if.spi_in); end
        checks++; if (u_if.byte_count !== 7'd1) begin failures++; $display("FAIL abort_byte_count: got %0d expected 1", u_if.byte_count); end
    endtask

    task automatic test_reset_mid_byte();
        int base;
        do_reset();
        select();
        send_byte(8'hC3);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rst       = 1'b1;
        u_if.ss_n = 1'b1;
        idle(1);
        checks++; if (u_if.spi_in !== 8'h00) begin failures++; $display("FAIL midrst_spi_in: got %0h expected 0", u_if.spi_in); end
        checks++; if (u_if.byte_count !== 7'd0) begin failures++; $display("FAIL midrst_byte_count: got %0d expected 0", u_if.byte_count); end
        checks++; if (u_if.shift_SPI !== 1'b0 || u_if.frame_ready !== 1'b0 || u_if.overrun_err !== 1'b0) begin
            failures++; $display("FAIL midrst_flags: got %0b%0b%0b expected 000", u_if.shift_SPI, u_if.frame_ready, u_if.overrun_err);
        end
        idle(2);
        rst = 1'b0;
        idle(3);
        base = pulse_cnt;
        select();
        send_byte(8'h81);
        idle(4);
        deselect();
        checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL midrst_pulses: got %0d expected 1", pulse_cnt - base); end
        checks++; if (u_if.spi_in !== 8'h81) begin failures++; $display("FAIL midrst_spi_in_after: got %0h expected 81", u_if.spi_in); end
        checks++; if (u_if.byte_count !== 7'd1) begin failures++; $display("FAIL midrst_count_after: got %0d expected 1", u_if.byte_count); end
    endtask

    task automatic test_ack_coincident();
        int         base;
        logic [7:0] b;
        do_reset();
        select();
        fill_frame();
        idle(4);
        checks++; if (u_if.overrun_err !== 1'b0) begin failures++; $display("FAIL coinc_pre_overrun: got %0b expected 0", u_if.overrun_err); end
        base = pulse_cnt;
        b = 8'h55;
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        // Last bit: ack held over exactly the clock edge that captures it.
        u_if.mosi = b[0];
        #40 u_if.sclk = 1'b1;
        #30 u_if.frame_ack = 1'b1;
        #10 u_if.frame_ack = 1'b0;
        u_if.sclk = 1'b0;
        #40;
        idle(4);
        deselect();
        checks++; if (u_if.frame_ready !== 1'b0) begin failures++; $display("FAIL coinc_frame_ready: got %0b expected 0", u_if.frame_ready); end
        checks++; if (u_if.byte_count !== 7'd0) begin failures++; $display("FAIL coinc_byte_count: got %0d expected 0", u_if.byte_count); end
        checks++; if (u_if.overrun_err !== 1'b1) begin failures++; $display("FAIL coinc_overrun: got %0b expected 1", u_if.overrun_err); end
        checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL coinc_no_pulse: got %0d expected 0", pulse_cnt - base); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (consec_err !== 0) begin failures++; $display("FAIL pulse_consecutive: got %0d expected 0", consec_err); end
        checks++; if (we_err !== 0) begin failures++; $display("FAIL write_en_match: got %0d expected 0", we_err); end
        checks++; if (hold_err !== 0) begin failures++; $display("FAIL spi_in_hold: got %0d changes expected 0", hold_err); end
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_full_frame();
        test_overrun_and_ack();
        test_abort();
        test_reset_mid_byte();
        test_ack_coincident();
        test_pulse_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
